// File: rtl/dualport_mailbox_pkg.sv
// Shared definitions for the dual-port mailbox RAM: mailbox word map helpers,
// channel limits and the channel bit-vector type.
package dualport_mailbox_pkg;

    localparam int MAX_NCH = 8;

    typedef logic [MAX_NCH-1:0] chan_vec_t;

    // Word address of left-to-right mailbox channel k (counted down from the top word).
    function automatic logic [31:0] mbox_l2r_word(input int aw, input int k);
        return (32'd1 << aw) - 32'd1 - 32'(k);
    endfunction

    // Word address of right-to-left mailbox channel k (below the left-to-right block).
    function automatic logic [31:0] mbox_r2l_word(input int aw, input int nch, input int k);
        return (32'd1 << aw) - 32'd1 - 32'(nch) - 32'(k);
    endfunction

endpackage

// File: rtl/dpramv.sv
// Byte-lane true dual-port RAM, independent clocks, 1-cycle registered reads.
// Each port owns one storage array; a word's value is the XOR of both arrays,
// so a port writes (data ^ other array) and the two clock domains never drive
// the same storage. Same-address writes from both ports leave the word undefined.
module dpramv #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clk_a,
    input  logic          rst_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] din_a,
    output logic [DW-1:0] dout_a,
    input  logic          clk_b,
    input  logic          rst_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] din_b,
    output logic [DW-1:0] dout_b
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];

    // Port A write and registered read (read every clock, output cleared in reset).
    always_ff @(posedge clk_a) begin
        if (we_a) begin
            mem_a[addr_a] <= din_a ^ mem_b[addr_a];
        end
        if (rst_a) begin
            dout_a <= '0;
        end else begin
            dout_a <= mem_a[addr_a] ^ mem_b[addr_a];
        end
    end

    // Port B write and registered read (read every clock, output cleared in reset).
    always_ff @(posedge clk_b) begin
        if (we_b) begin
            mem_b[addr_b] <= din_b ^ mem_a[addr_b];
        end
        if (rst_b) begin
            dout_b <= '0;
        end else begin
            dout_b <= mem_a[addr_b] ^ mem_b[addr_b];
        end
    end

endmodule

// File: rtl/mbox_toggle_sync.sv
// Two-flop synchroniser for level/toggle signals crossing into clk.
module mbox_toggle_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two-stage capture of the foreign-domain level; cleared by the local reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/dualport_mailbox_mc.sv
// Dual-port shared RAM with NCH doorbell mailboxes per direction.
// Left port: DW_L-wide, byte-lane writes, clk_l. Right port: byte-wide, clk_r.
// Top NCH words are left-to-right mailboxes, the next NCH right-to-left.
// Define MBOX_OVERRUN_EN to build the sticky overrun flags ovf_l/ovf_r.
module dualport_mailbox_mc
    import dualport_mailbox_pkg::*;
#(
    parameter int AW_L = 11,
    parameter int DW_L = 16,
    parameter int NCH  = 2,
    localparam int LANES = DW_L / 8,
    localparam int LB    = $clog2(LANES),
    localparam int LBW   = (LB > 0) ? LB : 1
) (
    input  logic               clk_l,
    input  logic               reset,
    input  logic               clk_r,
    input  logic               cs_l,
    input  logic [AW_L-1:0]    addr_l,
    input  logic [DW_L-1:0]    din_l,
    output logic [DW_L-1:0]    dout_l,
    input  logic [LANES-1:0]   we_l,
    output logic               int_l,
    output logic [NCH-1:0]     pend_l,
    input  logic               cs_r,
    input  logic [AW_L+LB-1:0] addr_r,
    input  logic [7:0]         din_r,
    output logic [7:0]         dout_r,
    input  logic               we_r,
    output logic               int_r,
    output logic [NCH-1:0]     pend_r,
    output logic [NCH-1:0]     ovf_l,
    output logic [NCH-1:0]     ovf_r
);

    // clk_l domain state
    logic [NCH-1:0] rq_r_q, rq_r_d, ack_l_q, ack_l_d;
    logic [NCH-1:0] ack_r_sync_l, rq_l_sync_l;
    logic [1:0]     rst_back_q, rst_back_d;
    // clk_r domain state
    logic [NCH-1:0] ack_r_q, ack_r_d, rq_l_q, rq_l_d;
    logic [NCH-1:0] rq_r_sync_r, ack_l_sync_r;
    logic [1:0]     rst_chain_q, rst_chain_d;
    logic [LBW-1:0] lane_q, lane_d;
    logic           rst_r;
    // decode
    logic [NCH-1:0] db_l_s, ackrd_l_s, db_r_s, ackrd_r_s;
    logic [AW_L-1:0] word_r_s;
    logic [LBW-1:0]  lane_r_s;
    logic [7:0]      lane_dout_s [LANES];

    assign word_r_s = addr_r[AW_L+LB-1:LB];

    if (LB > 0) begin : g_lane_sel
        assign lane_r_s = addr_r[LBW-1:0];
    end else begin : g_lane_one
        assign lane_r_s = 1'b0;
    end

    // Mailbox hit decode for both ports: doorbell writes and acknowledging reads.
    always_comb begin
        db_l_s    = '0;
        ackrd_l_s = '0;
        db_r_s    = '0;
        ackrd_r_s = '0;
        for (int k = 0; k < NCH; k++) begin
            db_l_s[k]    = cs_l && (we_l != '0) && (32'(addr_l) == mbox_l2r_word(AW_L, k));
            ackrd_l_s[k] = cs_l && (we_l == '0) && (32'(addr_l) == mbox_r2l_word(AW_L, NCH, k));
            db_r_s[k]    = cs_r && we_r && (32'(word_r_s) == mbox_r2l_word(AW_L, NCH, k));
            ackrd_r_s[k] = cs_r && !we_r && (32'(word_r_s) == mbox_l2r_word(AW_L, k));
        end
    end

    // Left-domain next state: L->R request toggles, R->L acks, and a
    // returned-reset guard that holds off handshakes until clk_r is out of reset.
    always_comb begin
        rq_r_d     = rq_r_q;
        ack_l_d    = ack_l_q;
        rst_back_d = {rst_back_q[0], rst_r};
        for (int k = 0; k < NCH; k++) begin
            if (db_l_s[k] && !rst_back_q[1]) begin
                rq_r_d[k] = ~ack_r_sync_l[k];
            end else begin
                rq_r_d[k] = rq_r_q[k];
            end
            if (ackrd_l_s[k] && !rst_back_q[1]) begin
                ack_l_d[k] = rq_l_sync_l[k];
            end else begin
                ack_l_d[k] = ack_l_q[k];
            end
        end
    end

    // Left-domain registers.
    always_ff @(posedge clk_l) begin
        if (reset) begin
            rq_r_q     <= '0;
            ack_l_q    <= '0;
            rst_back_q <= 2'b11;
        end else begin
            rq_r_q     <= rq_r_d;
            ack_l_q    <= ack_l_d;
            rst_back_q <= rst_back_d;
        end
    end

    // Right-domain next state: reset chain, L->R acks, R->L request toggles, lane select.
    always_comb begin
        rst_chain_d = {rst_chain_q[0], reset};
        ack_r_d     = ack_r_q;
        rq_l_d      = rq_l_q;
        lane_d      = lane_r_s;
        for (int k = 0; k < NCH; k++) begin
            if (ackrd_r_s[k]) begin
                ack_r_d[k] = rq_r_sync_r[k];
            end else begin
                ack_r_d[k] = ack_r_q[k];
            end
            if (db_r_s[k]) begin
                rq_l_d[k] = ~ack_l_sync_r[k];
            end else begin
                rq_l_d[k] = rq_l_q[k];
            end
        end
    end

    // Reset synchroniser into clk_r (it is the clk_r reset, so it is never cleared).
    always_ff @(posedge clk_r) begin
        rst_chain_q <= rst_chain_d;
    end

    assign rst_r = rst_chain_q[1];

    // Right-domain registers.
    always_ff @(posedge clk_r) begin
        if (rst_r) begin
            ack_r_q <= '0;
            rq_l_q  <= '0;
            lane_q  <= '0;
        end else begin
            ack_r_q <= ack_r_d;
            rq_l_q  <= rq_l_d;
            lane_q  <= lane_d;
        end
    end

    mbox_toggle_sync #(.W(NCH)) u_rq_r_sync  (.clk(clk_r), .rst(rst_r), .d(rq_r_q),  .q(rq_r_sync_r));
    mbox_toggle_sync #(.W(NCH)) u_ack_r_sync (.clk(clk_l), .rst(reset), .d(ack_r_q), .q(ack_r_sync_l));
    mbox_toggle_sync #(.W(NCH)) u_rq_l_sync  (.clk(clk_l), .rst(reset), .d(rq_l_q),  .q(rq_l_sync_l));
    mbox_toggle_sync #(.W(NCH)) u_ack_l_sync (.clk(clk_r), .rst(rst_r), .d(ack_l_q), .q(ack_l_sync_r));

    assign pend_r = rq_r_sync_r ^ ack_r_q;
    assign pend_l = rq_l_sync_l ^ ack_l_q;
    assign int_r  = |pend_r;
    assign int_l  = |pend_l;

`ifdef MBOX_OVERRUN_EN
    logic [NCH-1:0] ovf_r_q, ovf_r_d, ovf_l_q, ovf_l_d;

    // Overrun: doorbell while the writer still sees its previous request outstanding.
    always_comb begin
        ovf_r_d = ovf_r_q | (db_l_s & {NCH{~rst_back_q[1]}} & (rq_r_q ^ ack_r_sync_l));
        ovf_l_d = ovf_l_q | (db_r_s & (rq_l_q ^ ack_l_sync_r));
    end

    // Sticky L->R overrun flags, writer (clk_l) domain.
    always_ff @(posedge clk_l) begin
        if (reset) begin
            ovf_r_q <= '0;
        end else begin
            ovf_r_q <= ovf_r_d;
        end
    end

    // Sticky R->L overrun flags, writer (clk_r) domain.
    always_ff @(posedge clk_r) begin
        if (rst_r) begin
            ovf_l_q <= '0;
        end else begin
            ovf_l_q <= ovf_l_d;
        end
    end

    assign ovf_r = ovf_r_q;
    assign ovf_l = ovf_l_q;
`else
    assign ovf_r = '0;
    assign ovf_l = '0;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_ram
        dpramv #(.AW(AW_L), .DW(8)) u_ram (
            .clk_a  (clk_l),
            .rst_a  (reset),
            .we_a   (cs_l && we_l[g]),
            .addr_a (addr_l),
            .din_a  (din_l[8*g +: 8]),
            .dout_a (dout_l[8*g +: 8]),
            .clk_b  (clk_r),
            .rst_b  (rst_r),
            .we_b   (cs_r && we_r && (lane_r_s == LBW'(g))),
            .addr_b (word_r_s),
            .din_b  (din_r),
            .dout_b (lane_dout_s[g])
        );
    end

    assign dout_r = lane_dout_s[lane_q];

endmodule
